fetch_sequencer: RTL and testbench

Instruction fetch stage that sits directly upstream of the 16x8 instruction ROM. It owns the program counter, drives the ROM address and captures the returned 8-bit word into an instruction register. It presents the word to the downstream decoder over a valid/ready handshake. It resolves control flow itself (JMP, JZ, HALT), so the PC sequence is a function of the instruction stream and the zero flag from the datapath.

---
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the instruction ROM and the downstream decoder.
// The master side belongs to the sequencer. The slave side is the ROM/decoder environment.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output rom_addr,
        output instr_out,
        output instr_valid,
        input  rom_data,
        input  instr_ready
    );

    modport slave (
        input  rom_addr,
        input  instr_out,
        input  instr_valid,
        output rom_data,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: owns the PC, fetches from a combinational ROM and issues words
// over valid/ready. It resolves JMP/JZ/HALT locally.
module fetch_sequencer #(
    parameter int             ADDR_W   = 4,
    parameter int             DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]     OPC_JMP  = 4'b1000,
    parameter logic [3:0]     OPC_JZ   = 4'b1001,
    parameter logic [3:0]     OPC_HALT = 4'b1101
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                zero_flag,
    fetch_sequencer_if.master   bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [7:0]          retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_inc;

    assign opcode = instr_q[DATA_W-1 -: 4];
    assign target = instr_q[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = bus.rom_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // All control flow resolves on the handshake edge, so stalls freeze pc.
                if (bus.instr_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_FETCH;
                    if (opcode == OPC_JMP) begin
                        pc_d = target;
                    end else if (opcode == OPC_JZ) begin
                        pc_d = zero_flag ? target : pc_inc;
                    end else if (opcode == OPC_HALT) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = (state_q == S_ISSUE);
    assign pc              = pc_q;
    assign halted          = (state_q == S_HALTED);
    assign retired_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural program model predicts the issued
// instruction stream. A negedge monitor compares every cycle against it.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       zero_flag;
    logic       instr_ready;
    logic [3:0] pc;
    logic       halted;
    logic [7:0] retired_cnt;

    logic [7:0] rom [16];

    fetch_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    assign bus.rom_data    = rom[bus.rom_addr];
    assign bus.instr_ready = instr_ready;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .zero_flag   (zero_flag),
        .bus         (bus),
        .pc          (pc),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    // Reference model of the program: where execution is and what is waiting to be issued.
    logic [7:0] exp_q [$];
    logic [3:0] m_pc     = 4'd0;
    logic [7:0] m_cnt    = 8'd0;
    logic [7:0] m_ir     = 8'd0;
    bit         m_idle   = 1;
    bit         m_halted = 0;
    int         m_gap    = 0;
    bit         exp_valid;
    bit         hs;
    logic [7:0] issued;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] model_next_pc(input logic [3:0] cur, input logic [7:0] word,
                                                 input logic zf);
        int nxt;
        case (word[7:4])
            4'h8:    nxt = word[3:0];
            4'h9:    nxt = zf ? int'(word[3:0]) : (int'(cur) + 1) % 16;
            default: nxt = (int'(cur) + 1) % 16;
        endcase
        return nxt[3:0];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_valid = !m_idle && !m_halted && (m_gap == 0);
            check("instr_valid", instr_valid_w(), exp_valid);
            check("halted", halted, m_halted);
            check("pc", pc, m_pc);
            check("rom_addr", bus.rom_addr, m_pc);
            check("retired_cnt", retired_cnt, m_cnt);
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    m_ir = exp_q[0];
                    check("instr_out", bus.instr_out, m_ir);
                end
            end else begin
                check("instr_held", bus.instr_out, m_ir);
            end
            if (m_gap > 0) m_gap--;
            hs = exp_valid && instr_ready;
            if (rst) begin
                exp_q.delete();
                m_pc = 4'd0; m_cnt = 8'd0; m_ir = 8'd0;
                m_idle = 1; m_halted = 0; m_gap = 0;
            end else if (hs && exp_q.size() > 0) begin
                issued = exp_q.pop_front();
                m_cnt = m_cnt + 8'd1;
                if (issued[7:4] == 4'hD) begin
                    m_halted = 1;
                end else begin
                    m_pc = model_next_pc(m_pc, issued, zero_flag);
                    exp_q.push_back(rom[m_pc]);
                    m_gap = 1;
                end
            end else if (start && m_idle) begin
                m_idle = 0;
                exp_q.push_back(rom[m_pc]);
                m_gap = 1;
            end
        end
    end

    function automatic logic instr_valid_w();
        return bus.instr_valid;
    endfunction

    task automatic drive(input bit st, input bit rdy, input bit zf, input bit r);
        @(posedge clk);
        #2;
        start = st; instr_ready = rdy; zero_flag = zf; rst = r;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
    endtask

    initial begin
        rst = 1; start = 0; zero_flag = 0; instr_ready = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10;
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1;

        // Sequential run, ending in a HALT at address 4, with start pulses while halted.
        do_reset();
        rom[0] = 8'h12; rom[1] = 8'h25; rom[2] = 8'h36; rom[3] = 8'h43; rom[4] = 8'hD0;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 14; i++) drive(i % 3 == 0, 1, 0, 0);

        // Backpressure on 0x25 with zero_flag toggling during the stall.
        do_reset();
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, i[0], 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0);

        // Control flow: JMP/JZ chain, a NOP at 15 wrapping to 0, HALT at 12.
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'h10;
        rom[0] = 8'h87; rom[7] = 8'h82; rom[2] = 8'h88; rom[8] = 8'h91;
        rom[1] = 8'h8F; rom[15] = 8'h00; rom[9] = 8'h8C; rom[12] = 8'hD0;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0);
        end

        // Self-loop JMP 0 for more than 256 handshakes, then reset mid-issue and restart.
        do_reset();
        rom[0] = 8'h80;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 600; i++) drive(0, 1, 1'($urandom_range(0, 1)), 0);
        drive(0, 0, 0, 1);
        drive(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);

        // Random programs with random ready, zero_flag, start and occasional reset.
        for (int p = 0; p < 20; p++) begin
            do_reset();
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            drive(1, 1, 0, 0);
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
            end
        end

        drive(0, 0, 0, 0);
        @(posedge clk);
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
